// File: rtl/clk_div_ctrl.sv
// Run-time controller for a divided clock: start/stop and half-period reprogramming,
// with ratio changes and stops landing only on full-period boundaries (no runt pulses).
module clk_div_ctrl #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned DEF_HALF = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             cfg_valid_i,
  input  logic [CNT_W-1:0] cfg_half_i,
  output logic             cfg_ready_o,
  output logic             cfg_err_o,
  output logic             clk_out_o,
  output logic             tick_o,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cur_h_q;
  logic [CNT_W-1:0] pend_h_q;
  logic             pend_v_q;
  logic             cfg_ready_q;
  logic             cfg_err_q;
  logic             clk_out_q;
  logic             tick_q;

  logic cfg_fire;
  logic cfg_zero;
  logic cfg_take;
  logic phase_end;
  logic keep_run;

  assign cfg_fire  = cfg_valid_i && cfg_ready_q;
  assign cfg_zero  = (cfg_half_i == '0);
  assign cfg_take  = cfg_fire && !cfg_zero;
  assign phase_end = (cnt_q == (cur_h_q - CNT_W'(1)));
  // At a boundary the clock keeps running unless a stop is in progress and not cancelled.
  assign keep_run  = (state_q == ST_RUN) || (start_i && !stop_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cur_h_q     <= CNT_W'(DEF_HALF);
      pend_h_q    <= '0;
      pend_v_q    <= 1'b0;
      cfg_ready_q <= 1'b1;
      cfg_err_q   <= 1'b0;
      clk_out_q   <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      tick_q    <= 1'b0;
      cfg_err_q <= cfg_fire && cfg_zero;
      case (state_q)
        ST_IDLE: begin
          if (cfg_take) begin
            cur_h_q <= cfg_half_i;
          end
          if (start_i) begin
            state_q   <= ST_RUN;
            clk_out_q <= 1'b1;
            tick_q    <= 1'b1;
            cnt_q     <= '0;
          end
        end
        ST_RUN, ST_STOP: begin
          if (!(phase_end && !clk_out_q)) begin
            // Inside a period: count, fall at mid-period, park any new config.
            if (phase_end) begin
              cnt_q     <= '0;
              clk_out_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
            if (cfg_take) begin
              pend_h_q    <= cfg_half_i;
              pend_v_q    <= 1'b1;
              cfg_ready_q <= 1'b0;
            end
            if (state_q == ST_RUN && stop_i) begin
              state_q <= ST_STOP;
            end else if (state_q == ST_STOP && start_i && !stop_i) begin
              state_q <= ST_RUN;
            end
          end else begin
            // Period boundary: a config offered on this very edge is newer than any pending one.
            cnt_q <= '0;
            if (cfg_take) begin
              cur_h_q <= cfg_half_i;
            end else if (pend_v_q) begin
              cur_h_q <= pend_h_q;
            end
            pend_v_q    <= 1'b0;
            cfg_ready_q <= 1'b1;
            if (keep_run) begin
              clk_out_q <= 1'b1;
              tick_q    <= 1'b1;
              state_q   <= stop_i ? ST_STOP : ST_RUN;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          clk_out_q <= 1'b0;
          cnt_q     <= '0;
        end
      endcase
    end
  end

  assign cfg_ready_o = cfg_ready_q;
  assign cfg_err_o   = cfg_err_q;
  assign clk_out_o   = clk_out_q;
  assign tick_o      = tick_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: directed scenarios plus random traffic, checked every cycle
// against a period-position reference model.
module tb_clk_div_ctrl;

  localparam int unsigned CNT_W    = 8;
  localparam int unsigned DEF_HALF = 2;

  logic             clk;
  logic             rst;
  logic             start;
  logic             stop;
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_half;
  logic             cfg_ready;
  logic             cfg_err;
  logic             clk_out;
  logic             tick;
  logic [1:0]       state;

  int n_checks;
  int n_errors;

  // Reference model: position inside the current output period (0 .. 2H-1).
  int m_state;
  int m_h;
  int m_pos;
  int m_pend;
  bit m_pend_v;
  bit m_ready;
  bit m_err;
  bit m_tick;

  clk_div_ctrl #(.CNT_W(CNT_W), .DEF_HALF(DEF_HALF)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .stop_i      (stop),
    .cfg_valid_i (cfg_valid),
    .cfg_half_i  (cfg_half),
    .cfg_ready_o (cfg_ready),
    .cfg_err_o   (cfg_err),
    .clk_out_o   (clk_out),
    .tick_o      (tick),
    .state_o     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task model_step(input bit r, input bit s, input bit p, input bit cv, input int ch);
    bit fire;
    bit take;
    bit last;
    if (r) begin
      m_state  = 0;
      m_h      = DEF_HALF;
      m_pos    = 0;
      m_pend_v = 1'b0;
      m_ready  = 1'b1;
      m_err    = 1'b0;
      m_tick   = 1'b0;
      return;
    end
    fire   = cv && m_ready;
    take   = fire && (ch != 0);
    m_err  = fire && (ch == 0);
    m_tick = 1'b0;
    if (m_state == 0) begin
      if (take) m_h = ch;
      if (s) begin
        m_state = 1;
        m_pos   = 0;
        m_tick  = 1'b1;
      end
    end else begin
      last = (m_pos == 2 * m_h - 1);
      if (!last) begin
        m_pos++;
        if (take) begin
          m_pend   = ch;
          m_pend_v = 1'b1;
          m_ready  = 1'b0;
        end
        if (m_state == 1 && p) m_state = 2;
        else if (m_state == 2 && s && !p) m_state = 1;
      end else begin
        m_pos = 0;
        if (take) m_h = ch;
        else if (m_pend_v) m_h = m_pend;
        m_pend_v = 1'b0;
        m_ready  = 1'b1;
        if (m_state == 1 || (s && !p)) begin
          m_tick  = 1'b1;
          m_state = p ? 2 : 1;
        end else begin
          m_state = 0;
        end
      end
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, compare shortly after.
  task do_cycle(input bit r, input bit s, input bit p, input bit cv, input int ch);
    int exp_clk;
    rst       = r;
    start     = s;
    stop      = p;
    cfg_valid = cv;
    cfg_half  = CNT_W'(ch);
    @(posedge clk);
    model_step(r, s, p, cv, ch);
    #1;
    exp_clk = (m_state != 0 && m_pos < m_h) ? 1 : 0;
    check_eq("clk_out",   int'(clk_out),   exp_clk);
    check_eq("tick",      int'(tick),      int'(m_tick));
    check_eq("cfg_ready", int'(cfg_ready), int'(m_ready));
    check_eq("cfg_err",   int'(cfg_err),   int'(m_err));
    check_eq("state",     int'(state),     m_state);
  endtask

  task idle_cycles(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  initial begin
    int r_sel;
    int h_sel;
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    start     = 1'b0;
    stop      = 1'b0;
    cfg_valid = 1'b0;
    cfg_half  = '0;
    m_pend    = 0;
    model_step(1'b1, 1'b0, 1'b0, 1'b0, 0);

    do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 0);
    do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 0);

    // Default divide-by-4 run, then a mid-high-phase reconfig to H=5.
    do_cycle(1'b0, 1'b1, 1'b0, 1'b0, 0);
    idle_cycles(9);
    do_cycle(1'b0, 1'b0, 1'b0, 1'b1, 5);
    idle_cycles(30);

    // Zero config while running is rejected.
    do_cycle(1'b0, 1'b0, 1'b0, 1'b1, 0);
    idle_cycles(12);

    // H=3, stop pulse in the high phase, coast to IDLE.
    do_cycle(1'b0, 1'b0, 1'b0, 1'b1, 3);
    idle_cycles(20);
    do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 0);
    idle_cycles(12);

    // Start while IDLE, stop, then cancel the stop before the boundary.
    do_cycle(1'b0, 1'b1, 1'b1, 1'b0, 0);
    idle_cycles(1);
    do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 0);
    idle_cycles(1);
    do_cycle(1'b0, 1'b1, 1'b0, 1'b0, 0);
    idle_cycles(14);

    // H=1 run with reset mid-run.
    do_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1);
    idle_cycles(12);
    do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 0);
    idle_cycles(3);

    // Zero config in IDLE, then maximum half-period.
    do_cycle(1'b0, 1'b0, 1'b0, 1'b1, 0);
    do_cycle(1'b0, 1'b0, 1'b0, 1'b1, 255);
    do_cycle(1'b0, 1'b1, 1'b0, 1'b0, 0);
    idle_cycles(300);
    do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 0);
    idle_cycles(260);

    // Random traffic.
    for (int i = 0; i < 5000; i++) begin
      r_sel = $urandom_range(0, 9);
      if (r_sel == 0)      h_sel = 0;
      else if (r_sel == 9) h_sel = $urandom_range(6, 40);
      else                 h_sel = $urandom_range(1, 5);
      do_cycle($urandom_range(0, 499) == 0,
               $urandom_range(0, 99) < 10,
               $urandom_range(0, 99) < 7,
               $urandom_range(0, 99) < 12,
               h_sel);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
